sseg_mux_display: RTL and testbench
===================================

SSEG_MUX_DISPLAY -- requirements
Module: sseg_mux_display

Interface
REQ-001 SHALL have parameter NDIG, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, Clk cycles per digit slot (legal >= 2).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, full scan frames per blink half-period (legal >= 1).
REQ-004 SHALL have the following ports. One clock; reset is asynchronous and active-low.
REQ-005 Clk  in  1  system clock, all state on rising edge.
REQ-006 nReset  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  new display word offered.
REQ-008 in_ready  out  1  combinational; high only on the frame-boundary cycle.
REQ-009 value  in  4*NDIG  hex nibbles, nibble k shown on digit k (digit 0 rightmost).
REQ-010 neg  in  1  show minus sign on digit NDIG-1.
REQ-011 enable  in  1  0 blanks all digits.
REQ-012 blank_lz  in  1  leading-zero blanking.
REQ-013 blink_mask  in  NDIG  digits subject to blinking.
REQ-014 segs  out  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-015 dig_en  out  NDIG  active-low one-hot digit select, registered.
REQ-016 frame_done  out  1  one-cycle pulse per completed frame, registered.

Function
REQ-017 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; tick = (count == SCAN_DIV-1).
REQ-018 Digit index idx SHALL advance on tick, wrapping NDIG-1 -> 0.
REQ-019 in_ready SHALL equal tick AND (idx == NDIG-1); transfer = in_valid AND in_ready.
REQ-020 On transfer, value, neg, enable, blank_lz, blink_mask SHALL be captured together into shadow registers; display uses shadow only (no tearing).
REQ-021 Captured word SHALL first appear on digit 0 of the next frame, one cycle after transfer.
REQ-022 in_valid without in_ready SHALL have no effect; inputs may change freely between boundaries.
REQ-023 segs/dig_en SHALL be registered: one-cycle latency from idx to output.
REQ-024 Digit content priority: enable_q=0 -> blank; digit NDIG-1 with neg_q=1 -> minus (7'b011_1111, nibble ignored); leading-zero-blanked -> blank; blink-off -> blank; else hex glyph.
REQ-025 Hex glyphs SHALL match the team table: 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001, 5=001_0010, 6=000_0010, 7=111_1000, 8=000_0000, 9=001_1000, A=000_1000, b=000_0011, C=100_0110, d=010_0001, E=000_0110, F=000_1110; blank=111_1111.
REQ-026 Leading-zero blanking: digit k (k>0) blank when blank_lz_q=1 and all nibbles k..NDIG-1 (excluding a minus position) are zero; digit 0 never blanked by this rule.
REQ-027 frame_done SHALL pulse in the cycle after the idx NDIG-1 -> 0 wrap.

Reset
REQ-028 nReset low SHALL immediately force segs=7'h7F, dig_en=all ones, frame_done=0, count=0, idx=0, all shadow registers 0, blink phase 0.
REQ-029 Reset mid-frame SHALL discard the frame; scanning restarts at digit 0 on first edge after release.

Configuration
REQ-030 With SSEG_BLINK_EN defined, blink phase SHALL toggle every BLINK_FRAMES frames; phase=1 blanks digits whose blink_mask_q bit is 1.
REQ-031 Without SSEG_BLINK_EN, blink_mask port SHALL remain but be ignored and the blink counter SHALL not be built.

Structure
REQ-032 Package sseg_pkg SHALL hold glyph constants (SEG_BLANK, SEG_MINUS, hex table) and the 4-bit nibble typedef.
REQ-033 Glyph decode SHALL be the existing SSeg sub-module, one instance fed by the selected nibble.

Verification (NDIG=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-034 Reset release with no transfer -> segs=7'h7F every cycle, dig_en walks E,D,B,7 every 4 cycles.
REQ-035 Transfer value=16'h1234, enable=1, blank_lz=0 -> digits 0..3 show 001_1001, 011_0000, 010_0100, 111_1001, 4 cycles each.
REQ-036 value=16'h0050, blank_lz=1 -> digits 3,2 blank, digit 1 001_0010, digit 0 100_0000; value=0 -> only digit 0 lit (100_0000).
REQ-037 neg=1, value=16'h0012, blank_lz=1 -> digit 3 011_1111, digit 2 blank, digit 1 111_1001, digit 0 010_0100.
REQ-038 in_valid=1 with 16'hABCD asserted at idx=1 -> no change until boundary; 16'hABCD appears starting at digit 0 of the next frame; frame_done pulses once per 16 cycles.
REQ-039 SSEG_BLINK_EN, blink_mask=4'b0001 -> digit 0 lit for 2 frames, blank for 2 frames, repeating; nReset pulse at idx=2 -> outputs reset within the same cycle.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared seven-segment glyph constants and nibble type for the multiplexed display.
package sseg_pkg;

  typedef logic [3:0] nibble_t;

  // Active-low segment order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic [6:0] SEG_MINUS = 7'b011_1111;

  // Indexed by nibble value; entry 15 first
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b000_1110, 7'b000_0110, 7'b010_0001, 7'b100_0110,
    7'b000_0011, 7'b000_1000, 7'b001_1000, 7'b000_0000,
    7'b111_1000, 7'b000_0010, 7'b001_0010, 7'b001_1001,
    7'b011_0000, 7'b010_0100, 7'b111_1001, 7'b100_0000
  };

endpackage

// File: rtl/sseg_mux_display_sseg.sv
// Hex nibble to active-low seven-segment glyph decoder.
module sseg_mux_display_sseg
  import sseg_pkg::*;
(
  input  nibble_t    nib,
  output logic [6:0] segs_c
);

  assign segs_c = SEG_HEX[nib];

endmodule

// File: rtl/sseg_mux_display.sv
// Time-multiplexed NDIG-digit seven-segment driver with frame-aligned word capture.
// Optional digit blinking is built when SSEG_BLINK_EN is defined.
module sseg_mux_display
  import sseg_pkg::*;
#(
  parameter int unsigned NDIG         = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] value,
  input  logic              neg,
  input  logic              enable,
  input  logic              blank_lz,
  input  logic [NDIG-1:0]   blink_mask,
  output logic [6:0]        segs,
  output logic [NDIG-1:0]   dig_en,
  output logic              frame_done
);

  localparam int unsigned CNT_W   = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W   = $clog2(NDIG);
  localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);

  logic [CNT_W-1:0]             count;
  logic [IDX_W-1:0]             idx;
  logic                         tick;
  logic                         last_idx;
  logic                         transfer;

  nibble_t [NDIG-1:0]           val_q;
  logic                         neg_q;
  logic                         en_q;
  logic                         lz_q;

  logic [NDIG-1:0]              lz;
  logic                         lz_run;
  logic                         blink_off;
  logic [6:0]                   hex_c;
  logic [6:0]                   glyph;

  assign tick     = (count == CNT_W'(SCAN_DIV - 1));
  assign last_idx = (idx == IDX_W'(NDIG - 1));
  assign in_ready = tick & last_idx;
  assign transfer = in_valid & in_ready;

  // Slot counter and digit index
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
      idx   <= '0;
    end else if (tick) begin
      count <= '0;
      idx   <= last_idx ? '0 : idx + IDX_W'(1);
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Shadow word, only updated at the frame boundary so a frame never tears
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      val_q <= '0;
      neg_q <= 1'b0;
      en_q  <= 1'b0;
      lz_q  <= 1'b0;
    end else if (transfer) begin
      val_q <= value;
      neg_q <= neg;
      en_q  <= enable;
      lz_q  <= blank_lz;
    end
  end

`ifdef SSEG_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase_q;
  logic [NDIG-1:0]    mask_q;

  // Frame counter toggling the blink phase every BLINK_FRAMES frames
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      blink_cnt <= '0;
      phase_q   <= 1'b0;
      mask_q    <= '0;
    end else begin
      if (transfer) mask_q <= blink_mask;
      if (in_ready) begin
        if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          phase_q   <= ~phase_q;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

  assign blink_off = phase_q & mask_q[idx];
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blink_off    = 1'b0;
`endif

  // Leading-zero run from the top digit down; a minus position counts as zero
  always_comb begin
    lz_run = 1'b1;
    lz     = '0;
    for (int k = int'(NDIG) - 1; k >= 0; k--) begin
      lz_run = lz_run & ((val_q[k] == 4'h0) | ((k == int'(NDIG) - 1) & neg_q));
      lz[k]  = lz_run & (k != 0) & lz_q;
    end
  end

  sseg_mux_display_sseg u_sseg (
    .nib    (val_q[idx]),
    .segs_c (hex_c)
  );

  always_comb begin
    glyph = hex_c;
    if (!en_q)                  glyph = SEG_BLANK;
    else if (last_idx && neg_q) glyph = SEG_MINUS;
    else if (lz[idx])           glyph = SEG_BLANK;
    else if (blink_off)         glyph = SEG_BLANK;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      segs       <= SEG_BLANK;
      dig_en     <= '1;
      frame_done <= 1'b0;
    end else begin
      segs       <= glyph;
      dig_en     <= ~(NDIG'(1) << idx);
      frame_done <= in_ready;
    end
  end

endmodule

// File: tb/tb_sseg_mux_display.sv
// Directed bench for sseg_mux_display (NDIG=4, SCAN_DIV=4, BLINK_FRAMES=2).
module tb_sseg_mux_display;

  logic        Clk = 1'b0;
  logic        nReset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] value;
  logic        neg;
  logic        enable;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [6:0]  segs;
  logic [3:0]  dig_en;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] G0 = 7'b100_0000, G1 = 7'b111_1001, G2 = 7'b010_0100;
  localparam logic [6:0] G3 = 7'b011_0000, G4 = 7'b001_1001, G5 = 7'b001_0010;
  localparam logic [6:0] G8 = 7'b000_0000, GA = 7'b000_1000, GB = 7'b000_0011;
  localparam logic [6:0] GC = 7'b100_0110, GD = 7'b010_0001;
  localparam logic [6:0] BL = 7'b111_1111, MI = 7'b011_1111;

  sseg_mux_display #(.NDIG(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .value      (value),
    .neg        (neg),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .segs       (segs),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  always #5 Clk = ~Clk;

  // Offer a word, hold it until the boundary, then scramble inputs after transfer
  task automatic apply_word(input logic [15:0] v, input logic n, input logic en,
                            input logic lz, input logic [3:0] m);
    bit seen = 0;
    value = v; neg = n; enable = en; blank_lz = lz; blink_mask = m; in_valid = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clk);
      if (in_ready) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      $display("FAIL apply_word timeout: in_ready not seen, required 1");
      n_fail++;
    end
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    value = ~v; neg = ~n; enable = ~en; blank_lz = ~lz; blink_mask = ~m;
  endtask

  // Check one full frame starting at digit 0 right after a boundary
  task automatic expect_frame(input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3, input string name);
    logic [6:0] exp [4];
    logic [3:0] exp_dig;
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int j = 0; j < 16; j++) begin
      @(posedge Clk);
      #1;
      exp_dig = ~(4'b0001 << (j / 4));
      n_checks++;
      if (segs !== exp[j/4]) begin
        $display("FAIL %s segs cycle %0d: got %b required %b", name, j, segs, exp[j/4]);
        n_fail++;
      end
      n_checks++;
      if (dig_en !== exp_dig) begin
        $display("FAIL %s dig_en cycle %0d: got %b required %b", name, j, dig_en, exp_dig);
        n_fail++;
      end
      n_checks++;
      if (frame_done !== (j == 15)) begin
        $display("FAIL %s frame_done cycle %0d: got %b required %b", name, j, frame_done, j == 15);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_dig;
    nReset = 1'b1;
    #2 nReset = 1'b0;
    #20;
    n_checks++;
    if (segs !== BL || dig_en !== 4'hF || frame_done !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL reset_state: got segs=%b dig_en=%b fd=%b rdy=%b required 1111111 1111 0 0",
               segs, dig_en, frame_done, in_ready);
      n_fail++;
    end
    @(negedge Clk);
    nReset = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(posedge Clk);
      #1;
      exp_dig = ~(4'b0001 << (j / 4));
      n_checks++;
      if (segs !== BL || dig_en !== exp_dig || frame_done !== (j == 15)) begin
        $display("FAIL reset_walk cycle %0d: got segs=%b dig_en=%b fd=%b required %b %b %b",
                 j, segs, dig_en, frame_done, BL, exp_dig, j == 15);
        n_fail++;
      end
    end
  endtask

  task automatic test_hex();
    apply_word(16'h1234, 1'b0, 1'b1, 1'b0, 4'h0);
    expect_frame(G4, G3, G2, G1, "hex_1234");
    apply_word(16'h0000, 1'b0, 1'b1, 1'b0, 4'h0);
    expect_frame(G0, G0, G0, G0, "hex_0000_nolz");
  endtask

  task automatic test_enable_off();
    apply_word(16'h1234, 1'b1, 1'b0, 1'b0, 4'h0);
    expect_frame(BL, BL, BL, BL, "enable_off");
  endtask

  task automatic test_lz();
    apply_word(16'h0050, 1'b0, 1'b1, 1'b1, 4'h0);
    expect_frame(G0, G5, BL, BL, "lz_0050");
    apply_word(16'h0000, 1'b0, 1'b1, 1'b1, 4'h0);
    expect_frame(G0, BL, BL, BL, "lz_0000");
  endtask

  task automatic test_neg();
    apply_word(16'h0012, 1'b1, 1'b1, 1'b1, 4'h0);
    expect_frame(G2, G1, BL, MI, "neg_0012");
    apply_word(16'h8888, 1'b1, 1'b1, 1'b0, 4'h0);
    expect_frame(G8, G8, G8, MI, "neg_8888");
  endtask

  // Word offered at idx=1 must wait for the frame boundary
  task automatic test_boundary();
    logic [6:0] old [4];
    logic [3:0] exp_dig;
    old[0] = G4; old[1] = G3; old[2] = G2; old[3] = G1;
    apply_word(16'h1234, 1'b0, 1'b1, 1'b0, 4'h0);
    expect_frame(G4, G3, G2, G1, "pre_boundary");
    repeat (4) @(posedge Clk);
    #1;
    value = 16'hABCD; neg = 1'b0; enable = 1'b1; blank_lz = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      n_checks++;
      if (in_ready !== (i == 11)) begin
        $display("FAIL boundary in_ready step %0d: got %b required %b", i, in_ready, i == 11);
        n_fail++;
      end
      @(posedge Clk);
      #1;
      exp_dig = ~(4'b0001 << ((4 + i) / 4));
      n_checks++;
      if (segs !== old[(4+i)/4] || dig_en !== exp_dig || frame_done !== (i == 11)) begin
        $display("FAIL boundary hold step %0d: got segs=%b dig_en=%b fd=%b required %b %b %b",
                 i, segs, dig_en, frame_done, old[(4+i)/4], exp_dig, i == 11);
        n_fail++;
      end
    end
    in_valid = 1'b0;
    value = 16'h5555;
    expect_frame(GD, GC, GB, GA, "boundary_abcd");
    expect_frame(GD, GC, GB, GA, "boundary_abcd_2");
  endtask

  task automatic test_blink();
`ifdef SSEG_BLINK_EN
    nReset = 1'b0;
    #3 nReset = 1'b1;
    apply_word(16'h1234, 1'b0, 1'b1, 1'b0, 4'b0001);
    for (int k = 1; k <= 5; k++)
      expect_frame(((k / 2) % 2 == 0) ? G4 : BL, G3, G2, G1, $sformatf("blink_frame%0d", k));
`else
    apply_word(16'h1234, 1'b0, 1'b1, 1'b0, 4'b1111);
    expect_frame(G4, G3, G2, G1, "blink_ignored_1");
    expect_frame(G4, G3, G2, G1, "blink_ignored_2");
`endif
  endtask

  // Asynchronous reset at idx=2 clears outputs at once and restarts at digit 0
  task automatic test_reset_mid();
    logic [3:0] exp_dig;
    apply_word(16'h1234, 1'b0, 1'b1, 1'b0, 4'h0);
    repeat (8) @(posedge Clk);
    @(negedge Clk);
    nReset = 1'b0;
    #1;
    n_checks++;
    if (segs !== BL || dig_en !== 4'hF || frame_done !== 1'b0) begin
      $display("FAIL reset_mid immediate: got segs=%b dig_en=%b fd=%b required 1111111 1111 0",
               segs, dig_en, frame_done);
      n_fail++;
    end
    @(negedge Clk);
    nReset = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge Clk);
      #1;
      exp_dig = ~(4'b0001 << (j / 4));
      n_checks++;
      if (segs !== BL || dig_en !== exp_dig) begin
        $display("FAIL reset_mid restart cycle %0d: got segs=%b dig_en=%b required %b %b",
                 j, segs, dig_en, BL, exp_dig);
        n_fail++;
      end
    end
  endtask

  initial begin
    in_valid = 1'b0; value = '0; neg = 1'b0; enable = 1'b0; blank_lz = 1'b0; blink_mask = '0;
    test_reset();
    test_hex();
    test_enable_off();
    test_lz();
    test_neg();
    test_boundary();
    test_blink();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
